approx_adder_error_monitor: RTL
===============================

Name: approx_adder_error_monitor

Overview:
- Streaming consumer of approximate-adder results; it sits at the output end of an approximate ripple-carry adder under evaluation.
- Per accepted sample {IN1, IN2, APPROX} it computes the exact sum IN1+IN2 and the absolute error distance |exact − APPROX|.
- Over a measurement window it accumulates sample count, erroneous-sample count, sum of absolute error (for MAE) and worst-case error with the operands that caused it.
- Results are handed to a downstream reader through a valid/ready report port.

Parameters:
- WIDTH, 16, operand width; APPROX and exact sum are WIDTH+1 bits.
- CNT_W, 32, width of the sample and error counters.
- ACC_W, 48, width of the absolute-error accumulator.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_start  in  1  pulse: clear accumulators, open window.
- cmd_done  in  1  pulse: close window, produce report.
- in_valid  in  1  sample valid.
- in_ready  out  1  monitor accepts sample.
- IN1  in  WIDTH  operand A.
- IN2  in  WIDTH  operand B.
- APPROX  in  WIDTH+1  approximate adder output for IN1/IN2.
- res_valid  out  1  report valid.
- res_ready  in  1  report consumed.
- res_count  out  CNT_W  samples accepted.
- res_err_count  out  CNT_W  samples with nonzero error.
- res_sum_err  out  ACC_W  sum of |error|.
- res_max_err  out  WIDTH+1  worst |error|.
- res_max_in1  out  WIDTH  IN1 of first worst-case sample.
- res_max_in2  out  WIDTH  IN2 of first worst-case sample.
- res_sat  out  1  any counter or accumulator saturated.

Behaviour:
- Reset: state IDLE. in_ready=0, res_valid=0. All res_* outputs 0, pipeline valid bits 0. Reset has priority over everything, including mid-window and mid-report; no report is produced.
- FSM states and transitions:
  - IDLE: cmd_start → ACCUM, clearing all accumulators and res_sat.
  - ACCUM: in_ready=1 (registered, high from the first cycle in ACCUM). A sample is accepted when in_valid&&in_ready. cmd_done → DRAIN; a sample accepted in that same cycle is included. cmd_start in ACCUM restarts the window: clear accumulators, stay in ACCUM, and discard samples still in flight.
  - DRAIN: in_ready=0. Wait until both pipeline stages are empty (at most 2 cycles), then go to REPORT.
  - REPORT: res_valid=1 and res_* held stable until res_ready. On res_valid&&res_ready → IDLE; res_valid drops the next cycle, and res_* keep their values until the next cmd_start.
  - cmd_done in IDLE or REPORT is ignored. cmd_start in DRAIN or REPORT is ignored.
- Pipeline:
  - Stage 1 registers exact = IN1+IN2 (WIDTH+1 bits, zero-extended) and err = exact ≥ APPROX ? exact−APPROX : APPROX−exact.
  - Stage 2 updates the accumulators.
  - Accept-to-accumulator latency is 2 cycles. Full throughput: one sample per cycle, no bubbles.
- Arithmetic:
  - count +1 per sample.
  - err_count +1 if err≠0.
  - sum_err += err (zero-extended).
  - max_err/max_in1/max_in2 update only on strictly greater err, so ties keep the first occurrence.
- Saturation: each counter and the accumulator saturates at all-ones instead of wrapping, and sets res_sat (sticky until cmd_start).
- The monitor never back-pressures in ACCUM. The upstream holds in_valid and data stable until accepted.

Decomposition:
- Package approx_mon_pkg holds the FSM state enum (IDLE, ACCUM, DRAIN, REPORT), the default widths, and a saturating-increment helper function.
- Sub-module error_distance_unit: combinational exact sum and absolute difference (WIDTH parameter). It is instantiated once, ahead of the stage-1 register.

Test Plan:
- Reset, cmd_start, one sample IN1=0, IN2=0, APPROX=0x00040 (6-LSB approximate adder output), cmd_done → report count=1, err_count=1, sum_err=64, max_err=64, max_in1=0, max_in2=0.
- Window of three back-to-back samples, each held one cycle with in_valid=1:
  - (1,0,0x00041) → err 64
  - (0xFFFF,0xFFFF,0x1FFC0) → err 62
  - (0x0040,0x0040,0x00080) → err 0
  - Required report: count=3, err_count=2, sum_err=126, max_err=64, max_in1=1.
- Tie on max: (0,0,0x40) then (1,0,0x41), both err 64 → max_in1=0 (first kept).
- res_ready held low 5 cycles in REPORT → res_valid stays 1 and res_* unchanged. res_ready=1 → IDLE next cycle. cmd_done pulsed in IDLE → no report.
- Saturation: CNT_W=4, 20 samples with err 0 → res_count=15, res_sat=1, err_count=0.
- rst asserted in DRAIN with 2 samples in flight → next cycle in_ready=0, res_valid=0, all res_*=0. A following cmd_start/cmd_done with no samples → count=0, res_sat=0.

Source files
------------

// File: rtl/approx_mon_pkg.sv
// rtl/approx_mon_pkg.sv - shared types, default widths and saturating helper for the error monitor
package approx_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } mon_state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 32;
  localparam int DEF_ACC_W = 48;

  // Increment that sticks at lim instead of wrapping; callers cast back to their width.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] lim);
    return (v >= lim) ? lim : v + 64'd1;
  endfunction

endpackage

// File: rtl/error_distance_unit.sv
// rtl/error_distance_unit.sv - exact sum of two operands and its distance from an approximate sum
module error_distance_unit #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH:0]   approx,
  output logic [WIDTH:0]   err
);

  logic [WIDTH:0] exact;

  always_comb begin
    exact = {1'b0, in1} + {1'b0, in2};
    err   = (exact >= approx) ? (exact - approx) : (approx - exact);
  end

endmodule

// File: rtl/approx_adder_error_monitor.sv
// rtl/approx_adder_error_monitor.sv - windowed error statistics for an approximate adder under test
module approx_adder_error_monitor
  import approx_mon_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_start,
  input  logic             cmd_done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] IN1,
  input  logic [WIDTH-1:0] IN2,
  input  logic [WIDTH:0]   APPROX,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_count,
  output logic [CNT_W-1:0] res_err_count,
  output logic [ACC_W-1:0] res_sum_err,
  output logic [WIDTH:0]   res_max_err,
  output logic [WIDTH-1:0] res_max_in1,
  output logic [WIDTH-1:0] res_max_in2,
  output logic             res_sat
);

  localparam logic [CNT_W-1:0] CNT_ONES = '1;
  localparam logic [ACC_W-1:0] ACC_ONES = '1;

  mon_state_t       state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             res_valid_q, res_valid_d;
  logic             s1_valid_q, s1_valid_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH:0]   s1_err_q, s1_err_d;
  logic [WIDTH-1:0] s1_in1_q, s1_in1_d, s1_in2_q, s1_in2_d;
  logic [CNT_W-1:0] count_q, count_d, err_count_q, err_count_d;
  logic [ACC_W-1:0] sum_err_q, sum_err_d;
  logic [WIDTH:0]   max_err_q, max_err_d;
  logic [WIDTH-1:0] max_in1_q, max_in1_d, max_in2_q, max_in2_d;
  logic             sat_q, sat_d;

  logic             accept;
  logic             clear;
  logic [WIDTH:0]   err_w;
  logic [ACC_W:0]   sum_w;

  error_distance_unit #(.WIDTH(WIDTH)) u_edu (
    .in1    (IN1),
    .in2    (IN2),
    .approx (APPROX),
    .err    (err_w)
  );

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_start) begin
          state_d = ACCUM;
          clear   = 1'b1;
        end
      end
      ACCUM: begin
        if (cmd_start)     clear   = 1'b1;
        else if (cmd_done) state_d = DRAIN;
      end
      DRAIN:   if (!s1_valid_q && !s2_valid_q) state_d = REPORT;
      REPORT:  if (res_valid_q && res_ready)   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == ACCUM);
    res_valid_d = (state_d == REPORT);
    accept      = in_valid && in_ready_q;

    // A restart throws away whatever is still travelling through the pipe.
    s1_valid_d = accept && !clear;
    s1_err_d   = accept ? err_w : s1_err_q;
    s1_in1_d   = accept ? IN1 : s1_in1_q;
    s1_in2_d   = accept ? IN2 : s1_in2_q;
    s2_valid_d = s1_valid_q && !clear;

    count_d     = count_q;
    err_count_d = err_count_q;
    sum_err_d   = sum_err_q;
    max_err_d   = max_err_q;
    max_in1_d   = max_in1_q;
    max_in2_d   = max_in2_q;
    sat_d       = sat_q;
    sum_w       = {1'b0, sum_err_q} + {{(ACC_W - WIDTH){1'b0}}, s1_err_q};

    if (clear) begin
      count_d     = '0;
      err_count_d = '0;
      sum_err_d   = '0;
      max_err_d   = '0;
      max_in1_d   = '0;
      max_in2_d   = '0;
      sat_d       = 1'b0;
    end else if (s1_valid_q) begin
      count_d = CNT_W'(sat_inc(64'(count_q), 64'(CNT_ONES)));
      if (count_q == CNT_ONES) sat_d = 1'b1;
      if (s1_err_q != '0) begin
        err_count_d = CNT_W'(sat_inc(64'(err_count_q), 64'(CNT_ONES)));
        if (err_count_q == CNT_ONES) sat_d = 1'b1;
      end
      if (sum_w[ACC_W]) begin
        sum_err_d = ACC_ONES;
        sat_d     = 1'b1;
      end else begin
        sum_err_d = sum_w[ACC_W-1:0];
      end
      // Strictly greater keeps the earliest worst-case operands on ties.
      if (s1_err_q > max_err_q) begin
        max_err_d = s1_err_q;
        max_in1_d = s1_in1_q;
        max_in2_d = s1_in2_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s1_err_q    <= '0;
      s1_in1_q    <= '0;
      s1_in2_q    <= '0;
      count_q     <= '0;
      err_count_q <= '0;
      sum_err_q   <= '0;
      max_err_q   <= '0;
      max_in1_q   <= '0;
      max_in2_q   <= '0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      res_valid_q <= res_valid_d;
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      s1_err_q    <= s1_err_d;
      s1_in1_q    <= s1_in1_d;
      s1_in2_q    <= s1_in2_d;
      count_q     <= count_d;
      err_count_q <= err_count_d;
      sum_err_q   <= sum_err_d;
      max_err_q   <= max_err_d;
      max_in1_q   <= max_in1_d;
      max_in2_q   <= max_in2_d;
      sat_q       <= sat_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign res_valid     = res_valid_q;
  assign res_count     = count_q;
  assign res_err_count = err_count_q;
  assign res_sum_err   = sum_err_q;
  assign res_max_err   = max_err_q;
  assign res_max_in1   = max_in1_q;
  assign res_max_in2   = max_in2_q;
  assign res_sat       = sat_q;

endmodule
